// File: rtl/ins_mem_pkg.sv
// Shared definitions for the loadable instruction memory and the decoder.
//   - INS_W_DEF / ADDR_W_DEF : default instruction and PC widths
//   - NOP_INS_DEF            : reset/fill value of every memory entry
//   - ST_RUN / ST_LOAD       : FSM state encodings, wrapped in state_e
package ins_mem_pkg;

  localparam int unsigned INS_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  localparam logic [INS_W_DEF-1:0] NOP_INS_DEF = 16'b0000001100000000;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_LOAD = 1'b1;

  typedef enum logic {
    StRun  = ST_RUN,
    StLoad = ST_LOAD
  } state_e;

endpackage

// File: rtl/ins_mem_prog_if.sv
// Bus between the CPU/loader side (master) and the instruction memory (slave).
//   Fetch  : pc, fetch_en -> res_ins, ins_valid
//   Loader : ld_start, ld_valid, ld_data, ld_last -> ld_ready, ld_done
//   Status : busy (CPU stalls the PC while high)
interface ins_mem_prog_if
  import ins_mem_pkg::*;
#(
  parameter int unsigned INS_W  = INS_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic [INS_W-1:0]  res_ins;
  logic              ins_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [INS_W-1:0]  ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              busy;

  modport master (
    output pc, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    input  res_ins, ins_valid, ld_ready, ld_done, busy
  );

  modport slave (
    input  pc, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    output res_ins, ins_valid, ld_ready, ld_done, busy
  );

endinterface

// File: rtl/ins_mem_array.sv
// DEPTH x INS_W register storage with one write port and a registered read port.
//   clk_i, rst_i        : clock, async active-high reset (all entries -> NOP_INS)
//   we_i/waddr_i/wdata_i: synchronous write
//   re_i/raddr_i        : read enable/address; rdata_o updates on the next edge
//   rdata_o             : registered read data, NOP_INS for raddr_i >= DEPTH
module ins_mem_array
  import ins_mem_pkg::*;
#(
  parameter int unsigned      INS_W   = INS_W_DEF,
  parameter int unsigned      ADDR_W  = ADDR_W_DEF,
  parameter int unsigned      DEPTH   = 16,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INS_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INS_W-1:0]  rdata_o
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [INS_W-1:0] mem_q [DEPTH];
  logic [INS_W-1:0] rdata_q;
  logic             rd_in_range;

  // A fully populated address space needs no range check.
  if (DEPTH >= (2 ** ADDR_W)) begin : g_full
    assign rd_in_range = 1'b1;
  end else begin : g_partial
    assign rd_in_range = ({1'b0, raddr_i} < DepthW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_INS;
      end
      rdata_q <= NOP_INS;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= rd_in_range ? mem_q[raddr_i] : NOP_INS;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_mem_prog.sv
// Run-time loadable instruction memory between the PC register and the decoder.
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus_io : fetch port (pc/fetch_en -> res_ins/ins_valid, 1-cycle latency) and
//            valid/ready program loader (ld_*), plus busy while loading
module ins_mem_prog
  import ins_mem_pkg::*;
#(
  parameter int unsigned      INS_W   = INS_W_DEF,
  parameter int unsigned      ADDR_W  = ADDR_W_DEF,
  parameter int unsigned      DEPTH   = 16,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF)
) (
  input logic           clk_i,
  input logic           rst_i,
  ins_mem_prog_if.slave bus_io
);

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ins_valid_q, ins_valid_d;
  logic              ld_done_q, ld_done_d;

  logic loading;
  logic accept;
  logic fetch;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      ptr_q       <= '0;
      ins_valid_q <= 1'b0;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ins_valid_q <= ins_valid_d;
      ld_done_q   <= ld_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ins_valid_d = fetch;
    ld_done_d   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus_io.ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          // Stop on the tagged last word or the final entry; the pointer never wraps.
          if (bus_io.ld_last || (ptr_q == LastPtr)) begin
            state_d   = StRun;
            ld_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs and datapath controls.
  always_comb begin
    loading = (state_q == StLoad);
    accept  = loading && bus_io.ld_valid;
    // A load request in RUN wins over a fetch in the same cycle.
    fetch   = !loading && bus_io.fetch_en && !bus_io.ld_start;
  end

  assign bus_io.ld_ready  = loading;
  assign bus_io.busy      = loading;
  assign bus_io.ins_valid = ins_valid_q;
  assign bus_io.ld_done   = ld_done_q;

  ins_mem_array #(
    .INS_W  (INS_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NOP_INS(NOP_INS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (accept),
    .waddr_i(ptr_q),
    .wdata_i(bus_io.ld_data),
    .re_i   (fetch),
    .raddr_i(bus_io.pc),
    .rdata_o(bus_io.res_ins)
  );

endmodule

// File: tb/tb_ins_mem_prog.sv
// Self-checking bench for ins_mem_prog: a 16-entry instance for the main
// scenarios and a 12-entry instance for the partial address map.
module tb_ins_mem_prog;
  import ins_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_mem_prog_if #(.INS_W(16), .ADDR_W(4)) bus ();
  ins_mem_prog_if #(.INS_W(16), .ADDR_W(4)) bus12 ();

  ins_mem_prog #(
    .INS_W(16), .ADDR_W(4), .DEPTH(16), .NOP_INS(16'h0300)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  ins_mem_prog #(
    .INS_W(16), .ADDR_W(4), .DEPTH(12), .NOP_INS(16'h0300)
  ) dut12 (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus12)
  );

  typedef struct {
    logic [3:0]  pc;
    logic        fetch_en;
    logic        ld_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic [15:0] exp_res;
    logic        exp_valid;
    logic        exp_ready;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t tbl [19];

  function automatic vec_t mk(int pc, int fe, int st, int lv, int d, int last,
                              int er, int ev, int erdy, int ed, int eb);
    vec_t v;
    v.pc        = pc[3:0];
    v.fetch_en  = fe[0];
    v.ld_start  = st[0];
    v.ld_valid  = lv[0];
    v.ld_data   = d[15:0];
    v.ld_last   = last[0];
    v.exp_res   = er[15:0];
    v.exp_valid = ev[0];
    v.exp_ready = erdy[0];
    v.exp_done  = ed[0];
    v.exp_busy  = eb[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] res, input logic v,
                         input logic r, input logic d, input logic b);
    chk({tag, " res_ins"}, bus.res_ins, res);
    chk({tag, " ins_valid"}, 16'(bus.ins_valid), 16'(v));
    chk({tag, " ld_ready"}, 16'(bus.ld_ready), 16'(r));
    chk({tag, " ld_done"}, 16'(bus.ld_done), 16'(d));
    chk({tag, " busy"}, 16'(bus.busy), 16'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc = '0; bus.fetch_en = 1'b0; bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus12.pc = '0; bus12.fetch_en = 1'b0; bus12.ld_start = 1'b0;
    bus12.ld_valid = 1'b0; bus12.ld_data = '0; bus12.ld_last = 1'b0;
  endtask

  initial begin
    // Short gapped load, then fetch/load priority and LD_START ignored mid-load.
    //            pc fe st lv data    last res     v  rdy d  b
    tbl[0]  = mk(0, 0, 1, 0, 'h0000, 0, 'h0203, 0, 1, 0, 1);
    tbl[1]  = mk(0, 0, 0, 1, 'h1111, 0, 'h0203, 0, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 'hDEAD, 1, 'h0203, 0, 1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 1, 'h2222, 0, 'h0203, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 'h0000, 0, 'h0203, 0, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, 'h3333, 1, 'h0203, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 'h0000, 0, 'h1111, 1, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 'h0000, 0, 'h2222, 1, 0, 0, 0);
    tbl[8]  = mk(2, 1, 0, 0, 'h0000, 0, 'h3333, 1, 0, 0, 0);
    tbl[9]  = mk(3, 1, 0, 0, 'h0000, 0, 'h0203, 1, 0, 0, 0);
    tbl[10] = mk(4, 1, 0, 0, 'h0000, 0, 'h0204, 1, 0, 0, 0);
    tbl[11] = mk(5, 1, 1, 0, 'h0000, 0, 'h0204, 0, 1, 0, 1);
    tbl[12] = mk(5, 1, 0, 0, 'h0000, 0, 'h0204, 0, 1, 0, 1);
    tbl[13] = mk(5, 0, 0, 1, 'h4444, 0, 'h0204, 0, 1, 0, 1);
    tbl[14] = mk(5, 1, 1, 0, 'h0000, 0, 'h0204, 0, 1, 0, 1);
    tbl[15] = mk(5, 0, 0, 1, 'h5555, 1, 'h0204, 0, 0, 1, 0);
    tbl[16] = mk(0, 1, 0, 0, 'h0000, 0, 'h4444, 1, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 'h0000, 0, 'h5555, 1, 0, 0, 0);
    tbl[18] = mk(5, 0, 0, 0, 'h0000, 0, 'h5555, 0, 0, 0, 0);

    rst = 1'b1;
    idle_inputs();
    #12;
    chk_all("reset", 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset dut12 busy", 16'(bus12.busy), 16'h0);
    chk("reset dut12 res_ins", bus12.res_ins, 16'h0300);
    rst = 1'b0;

    // Fetch every entry of a freshly reset memory.
    for (int i = 0; i < 16; i++) begin
      bus.pc = 4'(i);
      bus.fetch_en = 1'b1;
      step();
      chk($sformatf("nop fetch pc=%0d res_ins", i), bus.res_ins, 16'h0300);
      chk($sformatf("nop fetch pc=%0d ins_valid", i), 16'(bus.ins_valid), 16'h1);
    end
    bus.fetch_en = 1'b0;
    step();
    chk("fetch_en low ins_valid", 16'(bus.ins_valid), 16'h0);

    // Full 16-word back-to-back load.
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    chk_all("load entered", 16'h0300, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'h0200 + 16'(i);
      chk($sformatf("full load word %0d ld_ready", i), 16'(bus.ld_ready), 16'h1);
      step();
      if (i < 15) begin
        chk($sformatf("full load word %0d ld_done", i), 16'(bus.ld_done), 16'h0);
      end else begin
        chk_all("full load end", 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    bus.ld_valid = 1'b0;
    bus.pc = 4'd7;
    bus.fetch_en = 1'b1;
    step();
    chk_all("fetch pc=7 after load", 16'h0207, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.pc = 4'd3;
    step();
    chk("fetch pc=3 after load", bus.res_ins, 16'h0203);
    bus.fetch_en = 1'b0;
    step();
    chk("idle after load ins_valid", 16'(bus.ins_valid), 16'h0);

    // Table-driven short load and priority scenarios.
    for (int i = 0; i < 19; i++) begin
      bus.pc       = tbl[i].pc;
      bus.fetch_en = tbl[i].fetch_en;
      bus.ld_start = tbl[i].ld_start;
      bus.ld_valid = tbl[i].ld_valid;
      bus.ld_data  = tbl[i].ld_data;
      bus.ld_last  = tbl[i].ld_last;
      step();
      chk_all($sformatf("vec %0d", i), tbl[i].exp_res, tbl[i].exp_valid,
              tbl[i].exp_ready, tbl[i].exp_done, tbl[i].exp_busy);
    end
    idle_inputs();

    // Reset in the middle of a load.
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'h0900 + 16'(i);
      step();
    end
    chk("mid-load busy before reset", 16'(bus.busy), 16'h1);
    bus.ld_data = 16'h0905;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async reset mid-load", 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    bus.ld_valid = 1'b0;
    rst = 1'b0;
    bus.pc = 4'd2;
    bus.fetch_en = 1'b1;
    step();
    chk_all("fetch pc=2 after reset", 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.pc = 4'd0;
    step();
    chk("fetch pc=0 after reset", bus.res_ins, 16'h0300);
    bus.fetch_en = 1'b0;
    step();

    // DEPTH=12 instance: out-of-range fetch and full-length load.
    bus12.pc = 4'd3;
    bus12.fetch_en = 1'b1;
    step();
    bus12.pc = 4'd13;
    step();
    chk("d12 fetch pc=13 res_ins", bus12.res_ins, 16'h0300);
    chk("d12 fetch pc=13 ins_valid", 16'(bus12.ins_valid), 16'h1);
    bus12.fetch_en = 1'b0;
    bus12.ld_start = 1'b1;
    step();
    bus12.ld_start = 1'b0;
    chk("d12 load entered busy", 16'(bus12.busy), 16'h1);
    for (int i = 0; i < 12; i++) begin
      bus12.ld_valid = 1'b1;
      bus12.ld_data  = 16'h0A00 + 16'(i);
      step();
      if (i < 11) begin
        chk($sformatf("d12 word %0d ld_done", i), 16'(bus12.ld_done), 16'h0);
      end else begin
        chk("d12 last word ld_done", 16'(bus12.ld_done), 16'h1);
        chk("d12 last word busy", 16'(bus12.busy), 16'h0);
        chk("d12 last word ld_ready", 16'(bus12.ld_ready), 16'h0);
      end
    end
    bus12.ld_valid = 1'b0;
    bus12.fetch_en = 1'b1;
    bus12.pc = 4'd11;
    step();
    chk("d12 fetch pc=11", bus12.res_ins, 16'h0A0B);
    chk("d12 ld_done cleared", 16'(bus12.ld_done), 16'h0);
    bus12.pc = 4'd13;
    step();
    chk("d12 fetch pc=13 after load", bus12.res_ins, 16'h0300);
    bus12.pc = 4'd0;
    step();
    chk("d12 fetch pc=0 after load", bus12.res_ins, 16'h0A00);
    bus12.pc = 4'd12;
    step();
    chk("d12 fetch pc=12 after load", bus12.res_ins, 16'h0300);
    bus12.fetch_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
